// File: rtl/bfis_query_scheduler_if.sv
// Requester, engine and result-stream bundle for bfis_query_scheduler.
// slave is the scheduler's view; master is the surrounding fabric's view.
interface bfis_query_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DIM     = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ-1:0]        req_ready_out;
  logic [NUM_REQ*DIM*32-1:0] req_query_in;
  logic [NUM_REQ*16-1:0]     req_k_in;
  logic [NUM_REQ*32-1:0]     req_vertex_in;

  logic                      srch_start_out;
  logic [DIM*32-1:0]         srch_query_out;
  logic [15:0]               srch_k_out;
  logic [31:0]               srch_vertex_out;
  logic                      srch_abort_out;
  logic [31:0]               srch_result_in;
  logic                      srch_valid_in;

  logic [31:0]               res_data_out;
  logic [ID_W-1:0]           res_id_out;
  logic                      res_valid_out;
  logic                      res_last_out;
  logic                      res_timeout_out;
  logic                      busy_out;
  logic [2:0]                state_out;

  modport slave (
    input  req_valid_in, req_query_in,
    input  req_k_in, req_vertex_in,
    input  srch_result_in, srch_valid_in,
    output req_ready_out,
    output srch_start_out, srch_query_out,
    output srch_k_out, srch_vertex_out,
    output srch_abort_out,
    output res_data_out, res_id_out,
    output res_valid_out, res_last_out,
    output res_timeout_out,
    output busy_out, state_out
  );

  modport master (
    output req_valid_in, req_query_in,
    output req_k_in, req_vertex_in,
    output srch_result_in, srch_valid_in,
    input  req_ready_out,
    input  srch_start_out, srch_query_out,
    input  srch_k_out, srch_vertex_out,
    input  srch_abort_out,
    input  res_data_out, res_id_out,
    input  res_valid_out, res_last_out,
    input  res_timeout_out,
    input  busy_out, state_out
  );
endinterface

// File: rtl/bfis_query_scheduler.sv
// Round-robin front end sharing one bfis engine among NUM_REQ
// requesters; forwards k tagged results or a timeout marker.
module bfis_query_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int DIM         = 4,
  parameter int K_MAX       = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  bfis_query_scheduler_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam int QW   = DIM * 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] id_q;
  logic            found;
  logic [QW-1:0]   sel_query;
  logic [15:0]     sel_k;
  logic [15:0]     sel_k_eff;
  logic [31:0]     sel_vertex;

  logic [QW-1:0]   query_q;
  logic [15:0]     k_eff_q;
  logic [15:0]     count_q;
  logic [31:0]     vertex_q;
  logic [TW-1:0]   timer_q;

  logic [31:0]     res_data_q;
  logic [ID_W-1:0] res_id_q;
  logic            res_valid_q;
  logic            res_last_q;
  logic            res_to_q;

  logic grant;
  logic beat;
  logic final_beat;
  logic expire;

  // Scan above last_grant first, then wrap to the low indices.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && ID_W'(i) > last_grant
          && bus.req_valid_in[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && ID_W'(i) <= last_grant
          && bus.req_valid_in[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_query  = '0;
    sel_k      = '0;
    sel_vertex = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_query  = bus.req_query_in[i*QW +: QW];
        sel_k      = bus.req_k_in[i*16 +: 16];
        sel_vertex = bus.req_vertex_in[i*32 +: 32];
      end
    end
    unique case (1'b1)
      sel_k == 16'd0:       sel_k_eff = 16'd1;
      sel_k > 16'(K_MAX):   sel_k_eff = 16'(K_MAX);
      default:              sel_k_eff = sel_k;
    endcase
  end

  assign grant      = (state == S_IDLE) && found;
  assign beat       = (state == S_RUN) && bus.srch_valid_in;
  assign final_beat = beat && (count_q + 16'd1 == k_eff_q);
  assign expire     = (state == S_RUN) && !bus.srch_valid_in
                      && (timer_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (grant) state_nx = S_START;
      S_START: state_nx = S_RUN;
      S_RUN: begin
        if (final_beat)  state_nx = S_DONE;
        else if (expire) state_nx = S_ABORT;
      end
      S_DONE:  state_nx = S_IDLE;
      S_ABORT: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.srch_start_out = (state == S_START);
    bus.srch_abort_out = (state == S_DONE)
                         || (state == S_ABORT);
    bus.busy_out       = (state != S_IDLE);
    bus.state_out      = state;
    bus.req_ready_out  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      bus.req_ready_out[i] = rst_n_in && grant
                             && (winner == ID_W'(i));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_grant  <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      query_q     <= '0;
      k_eff_q     <= '0;
      count_q     <= '0;
      vertex_q    <= '0;
      timer_q     <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_to_q    <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_to_q    <= 1'b0;
      if (grant) begin
        query_q    <= sel_query;
        k_eff_q    <= sel_k_eff;
        vertex_q   <= sel_vertex;
        id_q       <= winner;
        last_grant <= winner;
        count_q    <= '0;
        timer_q    <= '0;
      end
      if (beat) begin
        res_valid_q <= 1'b1;
        res_data_q  <= bus.srch_result_in;
        res_id_q    <= id_q;
        res_last_q  <= final_beat;
        count_q     <= count_q + 16'd1;
        timer_q     <= '0;
      end else if (expire) begin
        res_valid_q <= 1'b1;
        res_last_q  <= 1'b1;
        res_to_q    <= 1'b1;
        res_data_q  <= 32'hFFFF_FFFF;
        res_id_q    <= id_q;
      end else if (state == S_RUN) begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

  assign bus.srch_query_out  = query_q;
  assign bus.srch_k_out      = k_eff_q;
  assign bus.srch_vertex_out = vertex_q;
  assign bus.res_data_out    = res_data_q;
  assign bus.res_id_out      = res_id_q;
  assign bus.res_valid_out   = res_valid_q;
  assign bus.res_last_out    = res_last_q;
  assign bus.res_timeout_out = res_to_q;
endmodule

// File: tb/tb_bfis_query_scheduler.sv
// Scoreboard bench for bfis_query_scheduler: the bench plays requesters
// and engine; expected beats come from a query-level reference model.
module tb_bfis_query_scheduler;
  localparam int NR = 3;
  localparam int DM = 4;
  localparam int KM = 16;
  localparam int TO = 50;
  localparam int IW = 2;
  localparam int QW = DM * 32;
  localparam int CW = 256;

  typedef struct {
    logic [31:0]   d;
    logic [IW-1:0] id;
    bit            lst;
    bit            tmo;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int to_cyc = -1;
  int ref_last = NR - 1;
  bit first_run;
  beat_t sb[$];
  beat_t mon_e;

  logic [NR-1:0] tv_mask;
  int            tv_k[NR];
  logic [QW-1:0] tv_q[NR];
  logic [31:0]   tv_v[NR];
  int            pl_gap[$];
  logic [31:0]   pl_res[$];
  bit            start_junk;
  bit            extra_done;
  int            rst_after;

  bfis_query_scheduler_if #(.NUM_REQ(NR), .DIM(DM)) bus ();

  bfis_query_scheduler #(
    .NUM_REQ(NR), .DIM(DM), .K_MAX(KM), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [CW-1:0] act,
                     input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] all_outs();
    return {bus.req_ready_out, bus.srch_start_out,
            bus.srch_query_out, bus.srch_k_out,
            bus.srch_vertex_out, bus.srch_abort_out,
            bus.res_data_out, bus.res_id_out,
            bus.res_valid_out, bus.res_last_out,
            bus.res_timeout_out, bus.busy_out, bus.state_out};
  endfunction

  // Reference: round-robin winner and clamped k.
  function automatic int pick(input logic [NR-1:0] m);
    for (int j = 1; j <= NR; j++)
      if (m[(ref_last + j) % NR]) return (ref_last + j) % NR;
    return -1;
  endfunction

  function automatic int keff(input int k);
    if (k == 0) return 1;
    if (k > KM) return KM;
    return k;
  endfunction

  task automatic add(input int g, input logic [31:0] r);
    pl_gap.push_back(g);
    pl_res.push_back(r);
  endtask

  task automatic clr_plan();
    pl_gap.delete();
    pl_res.delete();
    start_junk = 0;
    extra_done = 0;
    rst_after  = 0;
  endtask

  task automatic push(input logic [31:0] d, input int id,
                      input bit l, input bit t);
    beat_t b;
    b.d = d; b.id = IW'(id); b.lst = l; b.tmo = t;
    sb.push_back(b);
  endtask

  task automatic tick();
    @(negedge clk);
    if (first_run) begin
      chk("start_single_pulse", bus.srch_start_out, 0);
      first_run = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.res_valid_out) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected got=%0h id=%0d",
                 bus.res_data_out, bus.res_id_out);
      end else begin
        mon_e = sb.pop_front();
        chk("res_data", bus.res_data_out, mon_e.d);
        chk("res_id", bus.res_id_out, mon_e.id);
        chk("res_last", bus.res_last_out, mon_e.lst);
        chk("res_timeout", bus.res_timeout_out, mon_e.tmo);
      end
      if (bus.res_timeout_out) to_cyc = cyc;
    end
  end

  task automatic do_txn();
    int w, ke, cnt, nb, n_abort, last_ev;
    bit exp_to, stop, idle;
    logic [NR-1:0] rdy;
    for (int i = 0; i < NR; i++) begin
      bus.req_k_in[i*16 +: 16]      = 16'(tv_k[i]);
      bus.req_query_in[i*QW +: QW]  = tv_q[i];
      bus.req_vertex_in[i*32 +: 32] = tv_v[i];
    end
    bus.req_valid_in = tv_mask;
    w  = pick(tv_mask);
    ke = keff(tv_k[w]);
    rdy = '0;
    rdy[w] = 1'b1;
    #1;
    chk("req_ready", bus.req_ready_out, rdy);
    cnt = 0; nb = 0; exp_to = 0; stop = 0;
    if (rst_after > 0) begin
      nb = rst_after;
      for (int i = 0; i < nb; i++) push(pl_res[i], w, 0, 0);
    end else begin
      for (int i = 0; i < pl_res.size() && !stop; i++) begin
        if (pl_gap[i] >= TO) begin
          exp_to = 1;
          stop = 1;
        end else begin
          cnt++;
          nb++;
          push(pl_res[i], w, cnt == ke, 0);
          if (cnt == ke) stop = 1;
        end
      end
      if (!stop) exp_to = 1;
      if (exp_to) push(32'hFFFF_FFFF, w, 1, 1);
    end
    @(negedge clk);
    bus.req_valid_in = '0;
    ref_last = w;
    chk("srch_start", bus.srch_start_out, 1);
    chk("state_start", bus.state_out, 1);
    chk("srch_query", bus.srch_query_out, tv_q[w]);
    chk("srch_k", bus.srch_k_out, ke);
    chk("srch_vertex", bus.srch_vertex_out, tv_v[w]);
    bus.srch_valid_in  = start_junk;
    bus.srch_result_in = 32'hBAD0_0000 ^ $urandom;
    last_ev = cyc;
    first_run = 1;
    for (int i = 0; i < nb; i++) begin
      for (int g = 0; g < pl_gap[i]; g++) begin
        tick();
        bus.srch_valid_in = 0;
      end
      tick();
      bus.srch_valid_in  = 1;
      bus.srch_result_in = pl_res[i];
      last_ev = cyc;
    end
    if (rst_after > 0) begin
      @(negedge clk);
      bus.srch_valid_in = 0;
      bus.req_valid_in  = '1;
      #2 rst_n = 0;
      #1 chk("reset_mid_run", all_outs(), '0);
      repeat (2) @(negedge clk);
      bus.req_valid_in = '0;
      rst_n = 1;
      ref_last = NR - 1;
      return;
    end
    n_abort = 0; to_cyc = -1; idle = 0;
    for (int t = 0; t < 4 * TO && !idle; t++) begin
      tick();
      bus.srch_valid_in  = extra_done && (bus.state_out == 3'd3);
      bus.srch_result_in = 32'h0BAD_BEEF;
      if (bus.srch_abort_out) n_abort++;
      if (bus.state_out == 3'd0) idle = 1;
    end
    chk("back_to_idle", idle, 1);
    chk("abort_pulses", n_abort, 1);
    if (exp_to) chk("timeout_latency", to_cyc - last_ev, TO + 1);
  endtask

  task automatic rand_txn();
    int ke, n, r;
    clr_plan();
    tv_mask = NR'($urandom_range(1, (1 << NR) - 1));
    for (int i = 0; i < NR; i++) begin
      r = $urandom % 8;
      tv_k[i] = (r == 0) ? 0 : (r == 1) ? 40 : (r == 2) ? 16
              : (r == 3) ? 17 : $urandom_range(1, 5);
      tv_q[i] = {$urandom, $urandom, $urandom, $urandom};
      tv_v[i] = $urandom;
    end
    ke = keff(tv_k[pick(tv_mask)]);
    n = ke + $urandom_range(0, 2);
    if ($urandom % 4 == 0 && n > 1) n--;
    for (int i = 0; i < n; i++) begin
      r = $urandom % 25;
      add((r == 0) ? TO - 1 : (r == 1) ? TO : $urandom_range(0, 2),
          $urandom);
    end
    start_junk = $urandom % 2;
    extra_done = $urandom % 2;
    do_txn();
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.req_valid_in   = '1;
    bus.req_query_in   = '0;
    bus.req_k_in       = '0;
    bus.req_vertex_in  = '0;
    bus.srch_valid_in  = 0;
    bus.srch_result_in = '0;
    for (int i = 0; i < NR; i++) begin
      tv_k[i] = 1; tv_q[i] = '0; tv_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_state", all_outs(), '0);
    bus.req_valid_in = '0;
    @(negedge clk);
    rst_n = 1;

    clr_plan();
    tv_mask = 3'b001;
    tv_k[0] = 3;
    tv_q[0] = {32'd1, 32'd1, 32'd7, 32'd5};
    tv_v[0] = 32'd1;
    add(0, 32'd10); add(0, 32'd20); add(0, 32'd30);
    do_txn();

    for (int n = 0; n < 4; n++) begin
      clr_plan();
      tv_mask = 3'b011;
      tv_k = '{1, 1, 1};
      tv_q[0] = {4{$urandom}};
      tv_q[1] = {4{$urandom}};
      add(0, $urandom);
      do_txn();
    end

    clr_plan();
    tv_mask = 3'b001; tv_k[0] = 0; extra_done = 1;
    add(0, 32'h111); add(0, 32'h222);
    do_txn();

    clr_plan();
    tv_mask = 3'b010; tv_k[1] = 40; extra_done = 1;
    for (int i = 0; i < 18; i++) add(i % 2, 32'h1000 + i);
    do_txn();

    clr_plan();
    tv_mask = 3'b100; tv_k[2] = 3;
    add(0, 32'hABC); add(TO, 32'hDEF);
    do_txn();

    clr_plan();
    tv_mask = 3'b100; tv_k[2] = 2;
    add(1, 32'h55); add(TO - 1, 32'h66);
    do_txn();

    clr_plan();
    tv_mask = 3'b001; tv_k[0] = 1;
    add(TO, 32'h77);
    do_txn();

    clr_plan();
    tv_mask = 3'b001; tv_k[0] = 4; rst_after = 2;
    for (int i = 0; i < 4; i++) add(0, 32'h900 + i);
    do_txn();

    clr_plan();
    tv_mask = 3'b011; tv_k = '{1, 1, 1};
    add(0, 32'h3131);
    do_txn();

    clr_plan();
    tv_mask = 3'b001; tv_k[0] = 2; start_junk = 1;
    add(0, 32'h4141); add(0, 32'h4242);
    do_txn();

    for (int n = 0; n < 60; n++) rand_txn();

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bfis_query_scheduler.md
Name: bfis_query_scheduler

Overview:
- Shares one bfis vector-search engine between NUM_REQ query requesters (host/manta bridge, on-chip test generator, etc.).
- Round-robin arbitrates requests, latches the winner's query vector, k and entry vertex, then pulses the engine's start.
- Forwards the engine's top-k result stream tagged with the requester id, terminates after k beats, and aborts on timeout.
- Sits between the requester FIFOs and bfis; its result stream feeds the output FIFO read by manta.

Parameters:
- NUM_REQ, 2: number of requesters, ≥2.
- DIM, 4: query vector length in 32-bit words.
- K_MAX, 16: largest accepted k; larger requests are clamped.
- TIMEOUT_CYC, 1000000: idle cycles allowed between engine results before abort.
- ID_W = max(1, $clog2(NUM_REQ)): derived localparam.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous, active-low reset
- req_valid_in  in  NUM_REQ  per-requester request valid
- req_ready_out  out  NUM_REQ  per-requester accept; one-hot or zero
- req_query_in  in  NUM_REQ*DIM*32  packed query vectors; requester i occupies slice i
- req_k_in  in  NUM_REQ*16  requested k per requester
- req_vertex_in  in  NUM_REQ*32  entry vertex id per requester
- srch_start_out  out  1  one-cycle start pulse to bfis
- srch_query_out  out  DIM*32  latched query, held stable while busy
- srch_k_out  out  16  effective k, held stable while busy
- srch_vertex_out  out  32  latched entry vertex
- srch_abort_out  out  1  one-cycle pulse that stops/resets the engine
- srch_result_in  in  32  engine result vertex id
- srch_valid_in  in  1  engine result valid; no backpressure
- res_data_out  out  32  forwarded result
- res_id_out  out  ID_W  requester owning the result
- res_valid_out  out  1  result beat valid; one cycle per beat
- res_last_out  out  1  final beat of a query
- res_timeout_out  out  1  beat is a timeout marker
- busy_out  out  1  high in any state other than IDLE
- state_out  out  3  FSM encoding, routed to the LEDs

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs are 0 and the FSM is in IDLE.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - A reset mid-search emits no abort or result beat; the engine is reset separately.
- States and encodings: IDLE=0, START=1, RUN=2, DONE=3, ABORT=4.
- IDLE:
  - The winner is the first i with req_valid_in[i] set, scanning from last_grant+1 with wrap.
  - req_ready_out[winner] is driven combinationally, only in IDLE.
  - On valid&&ready, latch query, vertex and id, and compute k_eff: 0→1; >K_MAX→K_MAX; else k.
  - Set last_grant=winner, clear the result counter and timer, and go to START.
- START:
  - srch_start_out=1 for exactly this cycle.
  - srch_valid_in is ignored in this cycle.
  - Next state is RUN.
- RUN:
  - Each srch_valid_in registers srch_result_in into res_data_out with res_valid_out=1 and res_id_out=id on the next cycle (1-cycle latency). The counter increments and the timer clears.
  - The beat on which count reaches k_eff also carries res_last_out=1, and the FSM goes to DONE.
  - With no result, the timer increments. When it reaches TIMEOUT_CYC-1, go to ABORT.
  - If srch_valid_in coincides with the timeout cycle, the valid wins and the timer clears.
- DONE:
  - srch_abort_out=1 for one cycle to stop the engine, then IDLE.
  - srch_valid_in beats arriving in DONE are dropped.
- ABORT:
  - Emits one beat: res_valid_out=1, res_last_out=1, res_timeout_out=1, res_data_out=32'hFFFF_FFFF, res_id_out=id.
  - Pulses srch_abort_out=1, then IDLE.
- Output hold rules:
  - res_valid_out, res_last_out, res_timeout_out and srch_start_out are single-cycle pulses.
  - res_data_out and res_id_out hold their last value otherwise.
- Widths: the counter and k_eff are 16 bits; the timer is $clog2(TIMEOUT_CYC+1) bits; the counter never wraps.
- Requests arriving while busy wait; req_ready_out stays 0 outside IDLE.
- A requester dropping valid before grant is legal and not granted.
- Minimum turnaround is 4 cycles from grant to next possible grant (IDLE, START, RUN, DONE) for k=1.

Test Plan:
- Single query: req0 with k=3, query {5,7,1,1}, vertex 1; engine returns 10,20,30 → srch_start_out pulses once, srch_query_out={5,7,1,1}, three beats id=0, last only on 30, abort pulse in DONE, then IDLE.
- Round-robin: req0 and req1 held valid continuously, each k=1 → grants alternate 0,1,0,1; ready is never high for both at once.
- Clamp: k=0 gives one beat with last; k=40 with K_MAX=16 gives srch_k_out=16 and last on the 16th beat; extra engine beats are dropped.
- Timeout (TIMEOUT_CYC=50): one result, then silence → beat 0xFFFFFFFF with timeout=1 and last=1 arrives 50 cycles after the real beat, plus an abort pulse. A result on cycle 49 instead clears the timer.
- Async reset asserted mid-RUN (after 2 of 4 beats) → all outputs 0 immediately; after release, req0 wins first and no stale beats appear.
- Back-to-back: srch_valid_in asserted in START is ignored, and the count reaches k only from RUN beats.
